ks_sum_pipe: RTL and testbench
==============================

KS_SUM_PIPE -- requirements
Module: ks_sum_pipe

Interface
REQ-001 Ports: i_clk, input, 1, single clock; all state on rising edge.
REQ-002 Ports: i_rst, input, 1, reset; asynchronous and active-high.
REQ-003 Ports: i_valid, input, 1, upstream prefix terms valid this cycle.
REQ-004 Ports: o_ready, output, 1, block accepts a beat when high.
REQ-005 Ports: i_c0, input, 1, carry-in of the add.
REQ-006 Ports: i_pk, input, 13, group propagate after prefix level 3; i_pk[j] belongs to bit j+3.
REQ-007 Ports: i_gk, input, 16, group generate after prefix level 3.
REQ-008 Ports: i_p_save, input, 16, bitwise propagate A^B.
REQ-009 Ports: o_valid, output, 1, result valid.
REQ-010 Ports: i_ready, input, 1, downstream accepts a result.
REQ-011 Ports: o_sum, output, 16, (A+B+c0) mod 2^16.
REQ-012 Ports: o_cout, output, 1, carry out of bit 15.
REQ-013 Ports: o_ovf, output, 1, signed overflow; present only with KS_OVF_EN.

Function
REQ-014 Final prefix level: G[i] = i_gk[i] for i = 0..7; G[i] = i_gk[i] | (i_pk[i-3] & i_gk[i-8]) for i = 8..15.
REQ-015 Carry into bit i: c[0] = i_c0; c[i] = G[i-1] for i = 1..15.
REQ-016 Sum and carry out: o_sum[i] = i_p_save[i] ^ c[i]; o_cout = G[15].
REQ-017 Handshake: a beat transfers on a cycle with i_valid & o_ready; a result transfers on a cycle with o_valid & i_ready.
REQ-018 Latency: a beat accepted in cycle N SHALL appear on o_valid/o_sum in cycle N+1 when the output is empty or draining.
REQ-019 Storage: one output register plus one skid register; o_ready is driven only from registered state (no combinational i_ready -> o_ready path).
REQ-020 Skid states: EMPTY (o_valid=0, o_ready=1), ONE (o_valid=1, o_ready=1), FULL (o_valid=1, o_ready=0).
REQ-021 EMPTY -> ONE on accept.
REQ-022 ONE: accept without drain -> FULL, with the new beat held in skid; drain without accept -> EMPTY; accept with drain -> ONE, with the new beat loaded into the output register.
REQ-023 FULL: drain -> ONE, with the skid beat moved into the output register in the same edge; i_valid is ignored while o_ready = 0.
REQ-024 Ordering: results leave strictly in acceptance order; sustained throughput is 1 beat/cycle while i_ready = 1.
REQ-025 Stability: o_sum, o_cout and o_ovf SHALL hold stable while o_valid & !i_ready.
REQ-026 Data inputs are sampled only on accept; they are don't-care when i_valid = 0.

Reset
REQ-027 While i_rst = 1: state EMPTY, o_valid = 0, o_ready = 0, o_sum = 0, o_cout = 0, o_ovf = 0, skid register = 0.
REQ-028 On the first clock edge after i_rst falls, o_ready = 1.
REQ-029 Reset asserted mid-operation discards both held beats immediately and asynchronously, with no result emitted.

Configuration
REQ-030 Macro KS_OVF_EN defined: o_ovf port exists; o_ovf = c[15] ^ G[15], registered and skidded alongside o_sum.
REQ-031 Macro KS_OVF_EN undefined: o_ovf port and its storage are absent; all other behaviour is identical.

Verification
REQ-032 Scenario, basic add: A=0x00FF, B=0x0001, c0=0 driven through the upstream stages -> one cycle later o_valid=1, o_sum=0x0100, o_cout=0.
REQ-033 Scenario, full carry chain: A=0xFFFF, B=0x0000, c0=1 -> o_sum=0x0000, o_cout=1; with KS_OVF_EN, o_ovf=0.
REQ-034 Scenario, signed overflow (KS_OVF_EN): A=0x7FFF, B=0x0001, c0=0 -> o_sum=0x8000, o_cout=0, o_ovf=1.
REQ-035 Scenario, backpressure: i_ready=0 while 3 beats (1+1, 2+2, 3+3) are offered -> 2 accepted, then o_ready=0, and o_sum holds 0x0002; after i_ready=1, outputs 0x0002, 0x0004, 0x0006 in order with no loss or duplication.
REQ-036 Scenario, streaming: i_valid=i_ready=1 for 100 cycles with random A, B, c0 -> 100 results, each matching the golden (A+B+c0), o_ready constantly 1.
REQ-037 Scenario, reset in FULL: assert i_rst -> o_valid=0 and o_ready=0 at once; after release, no stale result appears and the next beat has latency 1.

Source files
------------

// File: rtl/ks_sum_pipe.sv
// ks_sum_pipe: final Kogge-Stone prefix level, sum/carry formation and a
// two-entry (output + skid) elastic output stage.
// Optional feature: define KS_OVF_EN to add the registered o_ovf output.
module ks_sum_pipe (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_c0,
    input  logic [12:0] i_pk,
    input  logic [15:0] i_gk,
    input  logic [15:0] i_p_save,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [15:0] o_sum,
`ifdef KS_OVF_EN
    output logic        o_ovf,
`endif
    output logic        o_cout
);

`ifdef KS_OVF_EN
    localparam int RW = 18;  // {ovf, cout, sum}
`else
    localparam int RW = 17;  // {cout, sum}
`endif

    typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

    state_t          state_q, state_d;
    logic            ready_q, ready_d;
    logic [RW-1:0]   out_q, skid_q, res_new;
    logic [15:0]     g_fin, carry, sum_new;
    logic            accept, drain, load_out, load_skid, sel_skid;

    // Last prefix level (span 8) and sum formation; c0 is already folded
    // into the group generates upstream, so G[i-1] is the carry into bit i.
    always_comb begin
        g_fin = i_gk;
        for (int i = 8; i < 16; i++)
            g_fin[i] = i_gk[i] | (i_pk[i-3] & i_gk[i-8]);
        carry    = {g_fin[14:0], i_c0};
        sum_new  = i_p_save ^ carry;
`ifdef KS_OVF_EN
        res_new  = {carry[15] ^ g_fin[15], g_fin[15], sum_new};
`else
        res_new  = {g_fin[15], sum_new};
`endif
    end

    assign accept = i_valid & ready_q;
    assign drain  = (state_q != EMPTY) & i_ready;

    // Skid control: next state and which register loads on this edge.
    always_comb begin
        state_d   = state_q;
        load_out  = 1'b0;
        load_skid = 1'b0;
        sel_skid  = 1'b0;
        case (state_q)
            EMPTY: if (accept) begin
                state_d  = ONE;
                load_out = 1'b1;
            end
            ONE: begin
                if (accept && !drain) begin
                    state_d   = FULL;
                    load_skid = 1'b1;
                end else if (!accept && drain) begin
                    state_d = EMPTY;
                end else if (accept && drain) begin
                    load_out = 1'b1;
                end
            end
            FULL: if (drain) begin
                state_d  = ONE;
                load_out = 1'b1;
                sel_skid = 1'b1;
            end
            default: state_d = EMPTY;
        endcase
        // ready is registered so downstream i_ready never reaches o_ready
        ready_d = (state_d != FULL);
    end

    // State and registered ready; ready stays low through reset.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q <= EMPTY;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
        end
    end

    // Output and skid data registers.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_q  <= '0;
            skid_q <= '0;
        end else begin
            if (load_out)  out_q  <= sel_skid ? skid_q : res_new;
            if (load_skid) skid_q <= res_new;
        end
    end

    assign o_ready = ready_q;
    assign o_valid = (state_q != EMPTY);
    assign o_sum   = out_q[15:0];
    assign o_cout  = out_q[16];
`ifdef KS_OVF_EN
    assign o_ovf   = out_q[17];
`endif

endmodule

// File: tb/tb_ks_sum_pipe.sv
// Directed bench for ks_sum_pipe: builds level-3 prefix terms from A/B/c0
// and checks results against plain A+B+c0 arithmetic.
module tb_ks_sum_pipe;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_c0 = 1'b0;
    logic [12:0] i_pk = '0;
    logic [15:0] i_gk = '0;
    logic [15:0] i_p_save = '0;
    logic        o_valid;
    logic        i_ready = 1'b0;
    logic [15:0] o_sum;
    logic        o_cout;
`ifdef KS_OVF_EN
    logic        o_ovf;
`endif

    int n_cmp = 0;
    int n_err = 0;

    ks_sum_pipe dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_c0(i_c0), .i_pk(i_pk), .i_gk(i_gk), .i_p_save(i_p_save),
        .o_valid(o_valid), .i_ready(i_ready), .o_sum(o_sum),
`ifdef KS_OVF_EN
        .o_ovf(o_ovf),
`endif
        .o_cout(o_cout)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Upstream model: bitwise p/g, c0 folded into g[0], then KS levels d=1,2,4.
    task automatic drive_beat(input logic [15:0] a, input logic [15:0] b, input logic c0);
        logic [15:0] p, g, pn, gn;
        p = a ^ b;
        g = a & b;
        g[0] = g[0] | (p[0] & c0);
        i_p_save = p;
        for (int d = 1; d < 8; d = d * 2) begin
            gn = g;
            pn = p;
            for (int i = d; i < 16; i++) begin
                gn[i] = g[i] | (p[i] & g[i-d]);
                pn[i] = p[i] & p[i-d];
            end
            g = gn;
            p = pn;
        end
        i_gk = g;
        i_pk = p[15:3];
        i_c0 = c0;
    endtask

    task automatic cyc();
        @(posedge i_clk);
        @(negedge i_clk);
    endtask

    logic [16:0] q_exp[$];
    logic [16:0] e;
    logic [15:0] ra, rb;
    logic        rc;
    int          n_res;

    initial begin
        // Reset state
        @(negedge i_clk);
        chk("rst_valid", o_valid, 0);
        chk("rst_ready", o_ready, 0);
        chk("rst_sum",   o_sum,   0);
        chk("rst_cout",  o_cout,  0);
`ifdef KS_OVF_EN
        chk("rst_ovf",   o_ovf,   0);
`endif
        i_rst = 1'b0;
        cyc();
        chk("ready_after_rst", o_ready, 1);

        // Basic add, latency 1
        i_ready = 1'b1;
        drive_beat(16'h00FF, 16'h0001, 1'b0); i_valid = 1'b1;
        cyc(); i_valid = 1'b0;
        chk("basic_valid", o_valid, 1);
        chk("basic_sum",   o_sum,   16'h0100);
        chk("basic_cout",  o_cout,  0);
        cyc();
        chk("basic_drained", o_valid, 0);

        // Full carry chain
        drive_beat(16'hFFFF, 16'h0000, 1'b1); i_valid = 1'b1;
        cyc(); i_valid = 1'b0;
        chk("chain_sum",  o_sum,  16'h0000);
        chk("chain_cout", o_cout, 1);
`ifdef KS_OVF_EN
        chk("chain_ovf",  o_ovf,  0);
`endif
        cyc();

`ifdef KS_OVF_EN
        // Signed overflow
        drive_beat(16'h7FFF, 16'h0001, 1'b0); i_valid = 1'b1;
        cyc(); i_valid = 1'b0;
        chk("ovf_sum",  o_sum,  16'h8000);
        chk("ovf_cout", o_cout, 0);
        chk("ovf_ovf",  o_ovf,  1);
        cyc();
`endif

        // Backpressure: three beats offered with downstream stalled
        i_ready = 1'b0;
        drive_beat(16'd1, 16'd1, 1'b0); i_valid = 1'b1;
        cyc();
        drive_beat(16'd2, 16'd2, 1'b0);
        cyc();
        chk("bp_full_ready", o_ready, 0);
        chk("bp_hold_sum",   o_sum,   16'h0002);
        drive_beat(16'd3, 16'd3, 1'b0);
        cyc();
        chk("bp_still_full", o_ready, 0);
        chk("bp_stable_sum", o_sum,   16'h0002);
        chk("bp_valid",      o_valid, 1);
        i_ready = 1'b1;
        cyc();
        chk("bp_out2", o_sum, 16'h0004);
        chk("bp_ready_back", o_ready, 1);
        cyc(); i_valid = 1'b0;
        chk("bp_out3", o_sum, 16'h0006);
        chk("bp_out3_valid", o_valid, 1);
        cyc();
        chk("bp_empty", o_valid, 0);

        // Streaming 100 random beats
        n_res = 0;
        for (int k = 0; k <= 100; k++) begin
            chk("stream_ready", o_ready, 1);
            if (o_valid) begin
                e = q_exp.pop_front();
                chk("stream_sum",  o_sum,  e[15:0]);
                chk("stream_cout", o_cout, e[16]);
                n_res++;
            end
            if (k < 100) begin
                ra = 16'($urandom);
                rb = 16'($urandom);
                rc = 1'($urandom_range(0, 1));
                drive_beat(ra, rb, rc);
                i_valid = 1'b1;
                q_exp.push_back({1'b0, ra} + {1'b0, rb} + {16'd0, rc});
            end else begin
                i_valid = 1'b0;
            end
            cyc();
        end
        chk("stream_count", n_res, 100);
        chk("stream_idle", o_valid, 0);

        // Reset while FULL
        i_ready = 1'b0;
        drive_beat(16'h1111, 16'h2222, 1'b0); i_valid = 1'b1;
        cyc();
        drive_beat(16'h3333, 16'h4444, 1'b0);
        cyc(); i_valid = 1'b0;
        chk("rf_full", o_ready, 0);
        #2 i_rst = 1'b1;
        #1;
        chk("rf_async_valid", o_valid, 0);
        chk("rf_async_ready", o_ready, 0);
        chk("rf_async_sum",   o_sum,   0);
        @(negedge i_clk);
        i_rst = 1'b0;
        i_ready = 1'b1;
        cyc();
        chk("rf_ready_back", o_ready, 1);
        chk("rf_no_stale",   o_valid, 0);
        drive_beat(16'd5, 16'd6, 1'b0); i_valid = 1'b1;
        cyc(); i_valid = 1'b0;
        chk("rf_lat_valid", o_valid, 1);
        chk("rf_lat_sum",   o_sum,   16'd11);
        cyc();
        chk("rf_drained", o_valid, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
